// File: rtl/not_not_pkg.sv
// Shared definitions for the instruction path: instruction codes, judge
// states and the verdict rule used by response_judge.
package not_not_pkg;

  localparam logic [2:0] INSTR_UP        = 3'b000;
  localparam logic [2:0] INSTR_DOWN      = 3'b001;
  localparam logic [2:0] INSTR_LEFT      = 3'b010;
  localparam logic [2:0] INSTR_RIGHT     = 3'b011;
  localparam logic [2:0] INSTR_NOT_LEFT  = 3'b100;
  localparam logic [2:0] INSTR_NOT_RIGHT = 3'b101;
  localparam logic [2:0] INSTR_NOTHING   = 3'b110;

  // Bit positions in the key/edge vector.
  localparam int unsigned KEY_UP    = 0;
  localparam int unsigned KEY_DOWN  = 1;
  localparam int unsigned KEY_LEFT  = 2;
  localparam int unsigned KEY_RIGHT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_INSTR,
    ST_WAIT_KEY,
    ST_JUDGE,
    ST_OVER
  } judge_state_t;

  // Timeout verdict: only the NOTHING codes (11x) are satisfied by silence.
  function automatic logic verdict(input logic [2:0] code, input logic [3:0] edges,
                                   input logic multi, input logic timed_out);
    if (timed_out) return (code[2:1] == 2'b11);
    if (multi) return 1'b0;
    case (code)
      INSTR_UP:        return edges[KEY_UP];
      INSTR_DOWN:      return edges[KEY_DOWN];
      INSTR_LEFT:      return edges[KEY_LEFT];
      INSTR_RIGHT:     return edges[KEY_RIGHT];
      INSTR_NOT_LEFT:  return !edges[KEY_LEFT];
      INSTR_NOT_RIGHT: return !edges[KEY_RIGHT];
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/response_judge_if.sv
// Instruction request/accept handshake plus the verdict pulse between the
// instruction path and response_judge.
interface response_judge_if;
  logic [2:0] instruction;
  logic       instr_valid;
  logic       next_instr;
  logic       result_valid;
  logic       result_correct;

  modport master (
    output instruction, instr_valid,
    input  next_instr, result_valid, result_correct
  );

  modport slave (
    input  instruction, instr_valid,
    output next_instr, result_valid, result_correct
  );
endinterface

// File: rtl/key_edge_detect.sv
// Rising-edge detector for the four direction keys, with a flag for more
// than one edge in the same cycle.
module key_edge_detect (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] keys,
  output logic [3:0] edges,
  output logic       multi_edge
);

  logic [3:0] prev;

  // History resets to all-ones so a key held through reset never looks new.
  always_ff @(posedge clock) begin
    if (!reset_n) prev <= '1;
    else          prev <= keys;
  end

  always_comb begin
    edges      = keys & ~prev;
    multi_edge = (edges & (edges - 4'd1)) != '0;
  end

endmodule

// File: rtl/response_judge.sv
// Game-side judge: requests an instruction, waits for it to be shown, judges
// the player's first key press (or timeout) and keeps score and lives.
module response_judge
  import not_not_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned SCORE_W        = 8,
  parameter int unsigned LIVES          = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  response_judge_if.slave    bus,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_left,
  input  logic               key_right,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               game_over
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  judge_state_t  state;
  logic [2:0]    code;
  logic [TW-1:0] timer;
  logic          next_instr_q;
  logic          result_valid_q;
  logic          result_correct_q;

  logic [3:0] edges;
  logic       multi_edge;
  logic       any_edge;
  logic       ok;

  key_edge_detect u_edges (
    .clock      (clock),
    .reset_n    (reset_n),
    .keys       ({key_right, key_left, key_down, key_up}),
    .edges      (edges),
    .multi_edge (multi_edge)
  );

  always_comb begin
    any_edge = |edges;
    ok       = verdict(code, edges, multi_edge, !any_edge);
  end

  // Score/lives change on the edge into JUDGE so they are valid alongside result_valid.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      code             <= '0;
      timer            <= '0;
      score            <= '0;
      lives            <= '0;
      game_over        <= 1'b0;
      next_instr_q     <= 1'b0;
      result_valid_q   <= 1'b0;
      result_correct_q <= 1'b0;
    end else begin
      next_instr_q   <= 1'b0;
      result_valid_q <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            score        <= '0;
            lives        <= 2'(LIVES);
            game_over    <= 1'b0;
            next_instr_q <= 1'b1;
            state        <= ST_REQ;
          end
        end
        ST_REQ: state <= ST_WAIT_INSTR;
        ST_WAIT_INSTR: begin
          if (bus.instr_valid) begin
            code  <= bus.instruction;
            timer <= '0;
            state <= ST_WAIT_KEY;
          end
        end
        ST_WAIT_KEY: begin
          timer <= timer + 1'b1;
          if (any_edge || timer == TIMER_LAST) begin
            result_valid_q   <= 1'b1;
            result_correct_q <= ok;
            if (ok) begin
              if (score != '1) score <= score + 1'b1;
            end else begin
              lives <= lives - 2'd1;
            end
            state <= ST_JUDGE;
          end
        end
        ST_JUDGE: begin
          if (lives == 2'd0) begin
            game_over <= 1'b1;
            state     <= ST_OVER;
          end else begin
            next_instr_q <= 1'b1;
            state        <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.next_instr     = next_instr_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.result_correct = result_correct_q;

endmodule

// File: tb/tb_response_judge.sv
// Self-checking bench for response_judge: directed table, hand sequences for
// game over / reset, and random rounds against a rule-level reference model.
module tb_response_judge;

  localparam int unsigned T = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] keys = '0;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;

  response_judge_if bus();

  response_judge #(.TIMEOUT_CYCLES(T), .SCORE_W(8), .LIVES(3)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .bus       (bus),
    .key_up    (keys[0]),
    .key_down  (keys[1]),
    .key_left  (keys[2]),
    .key_right (keys[3]),
    .score     (score),
    .lives     (lives),
    .game_over (game_over)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int m_score = 0;
  int m_lives = 0;

  typedef struct {
    logic [2:0] code;
    logic [3:0] base;
    int         delay;
    logic [3:0] mask;
    logic       exp_ok;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Expected verdict straight from the game rules.
  function automatic bit rule_verdict(input logic [2:0] c, input logic [3:0] e);
    int n = $countones(e);
    if (n == 0) return c >= 3'd6;
    if (n > 1) return 1'b0;
    if (c < 3'd4) return e == (4'b0001 << c);
    if (c == 3'd4) return e != 4'b0100;
    if (c == 3'd5) return e != 4'b1000;
    return 1'b0;
  endfunction

  task automatic restart();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_score = 0;
    m_lives = 3;
    check("restart_next_instr", int'(bus.next_instr), 1);
    check("restart_score", int'(score), 0);
    check("restart_lives", int'(lives), 3);
    check("restart_game_over", int'(game_over), 0);
  endtask

  // Entered with the DUT in REQ. Applies one full round and checks it.
  task automatic play_round(input logic [2:0] code, input logic [3:0] base, input int delay,
                            input logic [3:0] mask, input logic exp_ok, input bit noise);
    logic [3:0] new_edges;
    int early = 0;
    new_edges = mask & ~base;
    keys = base;
    tick();
    tick();
    early += int'(bus.result_valid);
    bus.instruction = code;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    bus.instruction = 3'($urandom);
    if (new_edges != '0) begin
      for (int i = 0; i < delay; i++) begin
        if (noise) begin
          bus.instr_valid = ($urandom_range(0, 3) == 0);
          start = ($urandom_range(0, 3) == 0);
        end
        tick();
        early += int'(bus.result_valid);
      end
      bus.instr_valid = 1'b0;
      start = 1'b0;
      keys = base | mask;
      tick();
    end else begin
      for (int i = 0; i < int'(T) - 1; i++) begin
        if (noise) begin
          bus.instr_valid = ($urandom_range(0, 3) == 0);
          start = ($urandom_range(0, 3) == 0);
        end
        tick();
        early += int'(bus.result_valid);
      end
      bus.instr_valid = 1'b0;
      start = 1'b0;
      tick();
    end
    if (exp_ok) begin
      if (m_score < 255) m_score++;
    end else begin
      m_lives--;
    end
    check("no_early_result", early, 0);
    check("result_valid", int'(bus.result_valid), 1);
    check("result_correct", int'(bus.result_correct), int'(exp_ok));
    check("score", int'(score), m_score);
    check("lives", int'(lives), m_lives);
    keys = '0;
    tick();
    check("result_valid_one_cycle", int'(bus.result_valid), 0);
    if (m_lives == 0) begin
      check("game_over", int'(game_over), 1);
      check("no_next_instr_over", int'(bus.next_instr), 0);
    end else begin
      check("next_instr_after_judge", int'(bus.next_instr), 1);
    end
  endtask

  initial begin
    bus.instruction = '0;
    bus.instr_valid = 1'b0;

    vecs[0]  = '{3'b000, 4'b0000, 3,  4'b0001, 1'b1};
    vecs[1]  = '{3'b100, 4'b0000, 1,  4'b0100, 1'b0};
    vecs[2]  = '{3'b100, 4'b0000, 0,  4'b0010, 1'b1};
    vecs[3]  = '{3'b101, 4'b0000, 2,  4'b1000, 1'b0};
    vecs[4]  = '{3'b011, 4'b0000, 0,  4'b0000, 1'b0};
    vecs[5]  = '{3'b110, 4'b0000, 0,  4'b0000, 1'b1};
    vecs[6]  = '{3'b111, 4'b0000, 0,  4'b0000, 1'b1};
    vecs[7]  = '{3'b010, 4'b0000, 15, 4'b0100, 1'b1};
    vecs[8]  = '{3'b000, 4'b0000, 4,  4'b0101, 1'b0};
    vecs[9]  = '{3'b101, 4'b0000, 0,  4'b0001, 1'b1};
    vecs[10] = '{3'b110, 4'b0000, 5,  4'b0001, 1'b0};
    vecs[11] = '{3'b000, 4'b0001, 2,  4'b0001, 1'b0};

    // Reset state.
    tick();
    tick();
    check("rst_score", int'(score), 0);
    check("rst_lives", int'(lives), 0);
    check("rst_game_over", int'(game_over), 0);
    check("rst_next_instr", int'(bus.next_instr), 0);
    check("rst_result_valid", int'(bus.result_valid), 0);
    reset_n = 1'b1;
    tick();

    restart();
    tick();
    check("next_instr_single_cycle", int'(bus.next_instr), 0);
    // Back in REQ-equivalent position: step into WAIT_INSTR is part of play_round,
    // so restart from IDLE is not possible; realign by one extra round entry.
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        // Already one cycle past REQ; play_round's first tick lands in WAIT_INSTR too.
      end
      if (m_lives == 0) restart();
      play_round(vecs[i].code, vecs[i].base, vecs[i].delay, vecs[i].mask, vecs[i].exp_ok, 1'b0);
    end

    // Game over holds with no further requests until start.
    begin
      int pulses = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        pulses += int'(bus.next_instr);
      end
      check("over_no_next_instr", pulses, 0);
      check("over_game_over_held", int'(game_over), 1);
    end
    restart();

    // Score saturation.
    for (int i = 0; i < 258; i++)
      play_round(3'b000, 4'b0000, 0, 4'b0001, 1'b1, 1'b0);
    check("score_saturated", int'(score), 255);

    // Random rounds against the rule model.
    for (int r = 0; r < 60; r++) begin
      logic [2:0] c;
      logic [3:0] b;
      logic [3:0] m;
      int kind;
      if (m_lives == 0) restart();
      c = 3'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      kind = $urandom_range(0, 3);
      if (kind == 0) m = 4'b0000;
      else if (kind == 3) m = 4'($urandom);
      else m = 4'b0001 << $urandom_range(0, 3);
      play_round(c, b, $urandom_range(0, T - 1), m, rule_verdict(c, m & ~b), 1'b1);
    end

    // Reset during WAIT_KEY.
    if (m_lives == 0) restart();
    tick();
    bus.instruction = 3'b000;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    keys = 4'b1111;
    tick();
    check("midrst_score", int'(score), 0);
    check("midrst_lives", int'(lives), 0);
    check("midrst_game_over", int'(game_over), 0);
    check("midrst_next_instr", int'(bus.next_instr), 0);
    check("midrst_result_valid", int'(bus.result_valid), 0);
    reset_n = 1'b1;
    begin
      int stray = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        stray += int'(bus.result_valid) + int'(bus.next_instr);
      end
      check("midrst_idle_quiet", stray, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
